// File: rtl/ecg_acc_pkg.sv
// Shared accumulator and int8 types for the MAC, requantization and pooling stages.
package ecg_acc_pkg;
    localparam int ACC_W  = 24;
    localparam int BIAS_W = 16;
    localparam int Q_W    = 8;
    localparam int Q_MAX  = 127;
    localparam int Q_MIN  = -128;

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [Q_W-1:0]   q_t;
endpackage

// File: rtl/requant_relu_unit_sat_clip.sv
// sat_clip_s8: combinational optional-ReLU plus saturation of a wide signed value to int8.
module sat_clip_s8
    import ecg_acc_pkg::*;
#(
    parameter int IN_W = ACC_W + 2
) (
    input  logic signed [IN_W-1:0] din,
    input  logic                   relu,
    output q_t                     dout,
    output logic                   clip
);
    localparam logic signed [IN_W-1:0] HI = IN_W'(Q_MAX);
    localparam logic signed [IN_W-1:0] LO = IN_W'(Q_MIN);

    // ReLU takes precedence over clipping; a zeroed negative is not a saturation event
    always_comb begin
        dout = q_t'(0);
        clip = 1'b0;
        if (relu && din[IN_W-1]) begin
            dout = q_t'(0);
            clip = 1'b0;
        end else if (din > HI) begin
            dout = q_t'(Q_MAX);
            clip = 1'b1;
        end else if (din < LO) begin
            dout = q_t'(Q_MIN);
            clip = 1'b1;
        end else begin
            dout = din[Q_W-1:0];
            clip = 1'b0;
        end
    end
endmodule

// File: rtl/requant_relu_unit.sv
// requant_relu_unit: bias add, arithmetic shift, optional ReLU and int8 saturation, 3-cycle latency.
// Define REQUANT_ROUND_EN to round half up in the shift stage instead of truncating.
module requant_relu_unit
    import ecg_acc_pkg::*;
#(
    parameter int ACC_W  = ecg_acc_pkg::ACC_W,
    parameter int BIAS_W = ecg_acc_pkg::BIAS_W,
    parameter int LAT    = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en_in,
    input  logic signed [ACC_W-1:0]  Xin,
    input  logic signed [BIAS_W-1:0] bias,
    input  logic [4:0]               shift,
    input  logic                     relu_en,
    output logic signed [Q_W-1:0]    Yout,
    output logic                     en_out,
    output logic [15:0]              sat_cnt
);
    localparam int S1_W = ACC_W + 1;
    localparam int S2_W = ACC_W + 2;

    if (LAT != 3) begin : g_lat_check
        $error("requant_relu_unit: LAT must be 3");
    end

    logic                     en_prev_r;
    logic signed [BIAS_W-1:0] bias_r;
    logic [4:0]               shift_r;
    logic                     relu_r;

    logic                     start_s;
    logic signed [BIAS_W-1:0] bias_eff_s;
    logic [4:0]               shift_eff_s;
    logic                     relu_eff_s;

    logic                     v1_r;
    logic signed [S1_W-1:0]   s1_r;
    logic [4:0]               shift1_r;
    logic                     relu1_r;
    logic signed [S1_W-1:0]   s1_s;

    logic                     v2_r;
    logic signed [S2_W-1:0]   s2_r;
    logic                     relu2_r;
    logic signed [S2_W-1:0]   s1_ext_s;
    logic signed [S2_W-1:0]   s2_s;

    q_t                       clip_y_s;
    logic                     clip_s;
    logic signed [Q_W-1:0]    yout_r;
    logic                     en_out_r;
    logic [15:0]              sat_cnt_r;

    assign start_s = en_in & ~en_prev_r;

    // First sample of a burst bypasses the config registers so it already sees the new settings
    always_comb begin
        if (start_s) begin
            bias_eff_s  = bias;
            shift_eff_s = shift;
            relu_eff_s  = relu_en;
        end else begin
            bias_eff_s  = bias_r;
            shift_eff_s = shift_r;
            relu_eff_s  = relu_r;
        end
    end

    assign s1_s = S1_W'(Xin) + S1_W'(bias_eff_s);

`ifdef REQUANT_ROUND_EN
    localparam logic [4:0] SH_LIM = 5'(ACC_W + 1);
    logic signed [S2_W-1:0] rnd_s;

    // Half-LSB rounding offset; beyond SH_LIM the result is pure sign bits and no offset applies
    always_comb begin
        s1_ext_s = S2_W'(s1_r);
        if (shift1_r != 5'd0 && shift1_r <= SH_LIM) begin
            rnd_s = {{(S2_W-1){1'b0}}, 1'b1} << (shift1_r - 5'd1);
        end else begin
            rnd_s = {S2_W{1'b0}};
        end
        s2_s = (s1_ext_s + rnd_s) >>> shift1_r;
    end
`else
    // Truncating arithmetic shift (floor)
    always_comb begin
        s1_ext_s = S2_W'(s1_r);
        s2_s     = s1_ext_s >>> shift1_r;
    end
`endif

    sat_clip_s8 #(
        .IN_W (S2_W)
    ) u_clip (
        .din  (s2_r),
        .relu (relu2_r),
        .dout (clip_y_s),
        .clip (clip_s)
    );

    // Burst-start detection and config capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_prev_r <= 1'b0;
            bias_r    <= {BIAS_W{1'b0}};
            shift_r   <= 5'd0;
            relu_r    <= 1'b0;
        end else begin
            en_prev_r <= en_in;
            if (start_s) begin
                bias_r  <= bias;
                shift_r <= shift;
                relu_r  <= relu_en;
            end
        end
    end

    // Stages 1 and 2 each carry their own config copy so overlapping bursts stay isolated
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r     <= 1'b0;
            s1_r     <= {S1_W{1'b0}};
            shift1_r <= 5'd0;
            relu1_r  <= 1'b0;
            v2_r     <= 1'b0;
            s2_r     <= {S2_W{1'b0}};
            relu2_r  <= 1'b0;
        end else begin
            v1_r     <= en_in;
            s1_r     <= s1_s;
            shift1_r <= shift_eff_s;
            relu1_r  <= relu_eff_s;
            v2_r     <= v1_r;
            s2_r     <= s2_s;
            relu2_r  <= relu1_r;
        end
    end

    // Stage 3 output registers and saturation counter; a burst start wins over a same-cycle clip
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            yout_r    <= {Q_W{1'b0}};
            en_out_r  <= 1'b0;
            sat_cnt_r <= 16'd0;
        end else begin
            en_out_r <= v2_r;
            yout_r   <= v2_r ? clip_y_s : {Q_W{1'b0}};
            if (start_s) begin
                sat_cnt_r <= 16'd0;
            end else if (v2_r && clip_s && sat_cnt_r != 16'hFFFF) begin
                sat_cnt_r <= sat_cnt_r + 16'd1;
            end
        end
    end

    assign Yout    = yout_r;
    assign en_out  = en_out_r;
    assign sat_cnt = sat_cnt_r;
endmodule

// File: tb/tb_requant_relu_unit.sv
// Randomized self-checking bench for requant_relu_unit against an arithmetic reference model.
module tb_requant_relu_unit;
    logic               clk = 1'b0;
    logic               rst_n;
    logic               en_in;
    logic signed [23:0] Xin;
    logic signed [15:0] bias;
    logic [4:0]         shift;
    logic               relu_en;
    logic signed [7:0]  Yout;
    logic               en_out;
    logic [15:0]        sat_cnt;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit en;
        int y;
        bit clip;
    } exp_t;

    exp_t    pipe_q[$];
    bit      m_prev_en;
    longint  m_bias;
    int      m_shift;
    bit      m_relu;
    int      m_sat;
    bit      m_start_last;

    always #5 clk = ~clk;

    requant_relu_unit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_in   (en_in),
        .Xin     (Xin),
        .bias    (bias),
        .shift   (shift),
        .relu_en (relu_en),
        .Yout    (Yout),
        .en_out  (en_out),
        .sat_cnt (sat_cnt)
    );

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input longint x, input longint b, input int sh, input bit r);
        exp_t   e;
        longint v;
        v = x + b;
`ifdef REQUANT_ROUND_EN
        if (sh > 0 && sh <= 25) v = v + (64'sd1 <<< (sh - 1));
`endif
        v = v >>> sh;
        e.en = 1'b1;
        if (r && v < 0) begin
            e.y = 0;    e.clip = 1'b0;
        end else if (v > 127) begin
            e.y = 127;  e.clip = 1'b1;
        end else if (v < -128) begin
            e.y = -128; e.clip = 1'b1;
        end else begin
            e.y = int'(v); e.clip = 1'b0;
        end
        return e;
    endfunction

    function automatic exp_t idle_e();
        exp_t e;
        e.en = 1'b0; e.y = 0; e.clip = 1'b0;
        return e;
    endfunction

    task automatic model_reset();
        pipe_q.delete();
        repeat (3) pipe_q.push_back(idle_e());
        m_prev_en = 1'b0; m_bias = 0; m_shift = 0; m_relu = 1'b0;
        m_sat = 0; m_start_last = 1'b0;
    endtask

    // One cycle: check the outputs due now, then drive the next input
    task automatic drive(input bit en, input longint x, input longint b, input int sh, input bit r);
        exp_t e;
        bit   start;
        @(negedge clk);
        e = pipe_q.pop_front();
        if (m_start_last) m_sat = 0;
        else if (e.en && e.clip && m_sat < 65535) m_sat++;
        check("en_out", en_out, e.en);
        check("yout", Yout, e.en ? e.y : 0);
        check("sat_cnt", sat_cnt, m_sat);
        start = en && !m_prev_en;
        if (start) begin
            m_bias = b; m_shift = sh; m_relu = r;
        end
        m_prev_en = en;
        m_start_last = start;
        en_in = en; Xin = x[23:0]; bias = b[15:0]; shift = sh[4:0]; relu_en = r;
        pipe_q.push_back(en ? model(x, m_bias, m_shift, m_relu) : idle_e());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0, 1'b0);
    endtask

    // Reset asserted between clock edges: outputs must clear without waiting for a clock
    task automatic reset_pulse();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        en_in = 1'b0;
        #1;
        check("rst_en_out", en_out, 1'b0);
        check("rst_yout", Yout, 0);
        check("rst_sat_cnt", sat_cnt, 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    logic signed [23:0] rx;
    logic signed [15:0] rb;
    int                 rsh;
    bit                 rr;
    int                 blen;
    int                 bgap;

    initial begin
        rst_n = 1'b0; en_in = 1'b0; Xin = 24'sd0; bias = 16'sd0; shift = 5'd0; relu_en = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("init_en_out", en_out, 1'b0);
        check("init_yout", Yout, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(6);

        // Basic path
        drive(1'b1, 100, 10, 2, 1'b0);
        drive(1'b1, -50, 10, 2, 1'b0);
        drive(1'b1, 6, 10, 2, 1'b0);
        idle(5);

        // Saturation
        drive(1'b1, 1000, 0, 0, 1'b0);
        drive(1'b1, -1000, 0, 0, 1'b0);
        drive(1'b1, 127, 0, 0, 1'b0);
        drive(1'b1, -128, 0, 0, 1'b0);
        idle(5);
        check("sat_total", sat_cnt, 2);

        // ReLU
        drive(1'b1, -5, 0, 0, 1'b1);
        drive(1'b1, 5, 0, 0, 1'b1);
        drive(1'b1, -200, 0, 0, 1'b1);
        idle(5);
        check("relu_sat", sat_cnt, 0);

        // Config isolation across a one-cycle gap; mid-burst config changes must be ignored
        drive(1'b1, 1, 0, 0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1, 30, 3, 1'b1);
        drive(1'b0, 0, 0, 0, 1'b0);
        drive(1'b1, 1, 4, 0, 1'b0);
        idle(5);

        // Oversized shifts yield sign bits
        drive(1'b1, -7, 0, 31, 1'b0);
        idle(1);
        drive(1'b1, 7000, 0, 30, 1'b0);
        idle(5);

        // Reset on the second cycle of a burst, then later once outputs are flowing
        drive(1'b1, 500, 0, 0, 1'b0);
        reset_pulse();
        idle(6);
        for (int i = 0; i < 5; i++) drive(1'b1, 300 + i, 0, 0, 1'b0);
        reset_pulse();
        idle(6);

        // Randomized bursts with random gaps (gap 0 merges into the previous burst)
        for (int n = 0; n < 60; n++) begin
            blen = $urandom_range(1, 10);
            bgap = $urandom_range(0, 2);
            for (int i = 0; i < blen; i++) begin
                rx = 24'($urandom);
                rb = 16'($urandom);
                if ($urandom_range(0, 1) == 1) begin
                    rx = 24'($urandom_range(0, 4000)) - 24'sd2000;
                    rb = 16'($urandom_range(0, 200)) - 16'sd100;
                end
                rsh = ($urandom_range(0, 7) == 0) ? $urandom_range(24, 31) : $urandom_range(0, 23);
                rr  = 1'($urandom_range(0, 1));
                drive(1'b1, rx, rb, rsh, rr);
            end
            idle(bgap);
        end
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
